// File: rtl/march_pkg.sv
// march_pkg: shared types and constants for the March fail logger.
//   state_e  : logger FSM states (IDLE, RUN, DRAIN, DONE)
//   STEP_W   : width of the March step index field
//   PHASE_W  : width of the step-1 sub-step field
//   PAT0/1   : background patterns used by the tester
//   log_w()  : width of one log entry, with or without a timestamp field
package march_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int STEP_W  = 3;
    localparam int PHASE_W = 2;

    localparam logic [7:0] PAT0 = 8'h55;
    localparam logic [7:0] PAT1 = 8'hAA;

    function automatic int log_w(input int addr_w, input int data_w,
                                 input int ts_w, input bit ts_en);
        return (ts_en ? ts_w : 0) + STEP_W + PHASE_W + addr_w + 2 * data_w;
    endfunction

endpackage

// File: rtl/march_log_fifo.sv
// march_log_fifo: synchronous show-ahead FIFO holding failure log entries.
// The head entry is presented on rdata whenever empty is low; rdata reads
// as zero while the FIFO is empty.
//   clk, reset : clock, synchronous active-low reset
//   clr        : synchronous flush (discards all entries)
//   push/wdata : write request; accepted when not full, or full with a pop
//   pop        : remove head; ignored while empty
//   rdata      : head entry
//   full/empty : occupancy flags
module march_log_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot this cycle, so a push into a full FIFO fits.
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/march_fail_logger.sv
// march_fail_logger: captures failing read-compares from a March memory
// tester into a show-ahead log FIFO, keeps saturating compare/fail counts,
// records the first failing address and produces a pass/fail verdict.
// Optional build macro: MARCH_LOG_TIMESTAMP_EN prepends a TS_W-bit cycle
// timestamp (running in RUN and DRAIN) to every log entry.
//   clk, reset          : clock, synchronous active-low reset
//   test_start          : pulse; clears all state and enters RUN
//   chk_*               : compare event (valid, fail, addr, step, phase, exp, act)
//   test_done           : tester finished (level)
//   log_valid/ready/data: FIFO head readout handshake
//   fail_count, check_count, first_fail_valid, first_fail_addr, overflow
//   done, pass, busy    : status
module march_fail_logger
    import march_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 16,
    parameter int TS_W   = 24,
`ifdef MARCH_LOG_TIMESTAMP_EN
    localparam int LOG_W = log_w(ADDR_W, DATA_W, TS_W, 1'b1)
`else
    localparam int LOG_W = log_w(ADDR_W, DATA_W, TS_W, 1'b0)
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               test_start,
    input  logic               chk_valid,
    input  logic               chk_fail,
    input  logic [ADDR_W-1:0]  chk_addr,
    input  logic [STEP_W-1:0]  chk_step,
    input  logic [PHASE_W-1:0] chk_phase,
    input  logic [DATA_W-1:0]  chk_exp,
    input  logic [DATA_W-1:0]  chk_act,
    input  logic               test_done,
    output logic               log_valid,
    input  logic               log_ready,
    output logic [LOG_W-1:0]   log_data,
    output logic [CNT_W-1:0]   fail_count,
    output logic [CNT_W-1:0]   check_count,
    output logic               first_fail_valid,
    output logic [ADDR_W-1:0]  first_fail_addr,
    output logic               overflow,
    output logic               done,
    output logic               pass,
    output logic               busy
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  fail_count_q, fail_count_d;
    logic [CNT_W-1:0]  check_count_q, check_count_d;
    logic              first_fail_valid_q, first_fail_valid_d;
    logic [ADDR_W-1:0] first_fail_addr_q, first_fail_addr_d;
    logic              overflow_q, overflow_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;

    logic              capture, fail_push, pop_acc;
    logic              fifo_full, fifo_empty;
    logic [LOG_W-1:0]  entry;

    // A start pulse wins over a same-cycle compare; the compare is discarded.
    assign capture   = (state_q == RUN) & chk_valid & ~test_start;
    assign fail_push = capture & chk_fail;
    assign pop_acc   = log_valid & log_ready;

`ifdef MARCH_LOG_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q, ts_d;

    always_comb begin
        ts_d = ts_q;
        if (test_start)                             ts_d = '0;
        else if (state_q == RUN || state_q == DRAIN) ts_d = ts_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) ts_q <= '0;
        else        ts_q <= ts_d;
    end

    assign entry = {ts_q, chk_step, chk_phase, chk_addr, chk_exp, chk_act};
`else
    assign entry = {chk_step, chk_phase, chk_addr, chk_exp, chk_act};
`endif

    always_comb begin
        state_d            = state_q;
        fail_count_d       = fail_count_q;
        check_count_d      = check_count_q;
        first_fail_valid_d = first_fail_valid_q;
        first_fail_addr_d  = first_fail_addr_q;
        overflow_d         = overflow_q;
        done_d             = done_q;
        pass_d             = pass_q;
        if (test_start) begin
            state_d            = RUN;
            fail_count_d       = '0;
            check_count_d      = '0;
            first_fail_valid_d = 1'b0;
            first_fail_addr_d  = '0;
            overflow_d         = 1'b0;
            done_d             = 1'b0;
            pass_d             = 1'b0;
        end else begin
            if (capture) begin
                check_count_d = sat_inc(check_count_q);
                if (chk_fail) begin
                    fail_count_d = sat_inc(fail_count_q);
                    if (!first_fail_valid_q) begin
                        first_fail_valid_d = 1'b1;
                        first_fail_addr_d  = chk_addr;
                    end
                    // Dropped entry: full and no slot freed by a pop.
                    if (fifo_full && !pop_acc) overflow_d = 1'b1;
                end
            end
            case (state_q)
                RUN:     if (test_done) state_d = DRAIN;
                DRAIN: begin
                    if (fifo_empty) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        pass_d  = (fail_count_q == '0);
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q            <= IDLE;
            fail_count_q       <= '0;
            check_count_q      <= '0;
            first_fail_valid_q <= 1'b0;
            first_fail_addr_q  <= '0;
            overflow_q         <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
        end else begin
            state_q            <= state_d;
            fail_count_q       <= fail_count_d;
            check_count_q      <= check_count_d;
            first_fail_valid_q <= first_fail_valid_d;
            first_fail_addr_q  <= first_fail_addr_d;
            overflow_q         <= overflow_d;
            done_q             <= done_d;
            pass_q             <= pass_d;
        end
    end

    march_log_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (test_start),
        .push  (fail_push),
        .pop   (log_ready),
        .wdata (entry),
        .rdata (log_data),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign log_valid        = ~fifo_empty;
    assign fail_count       = fail_count_q;
    assign check_count      = check_count_q;
    assign first_fail_valid = first_fail_valid_q;
    assign first_fail_addr  = first_fail_addr_q;
    assign overflow         = overflow_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign busy             = (state_q == RUN) | (state_q == DRAIN);

endmodule

// File: tb/tb_march_fail_logger.sv
// tb_march_fail_logger: directed bench for march_fail_logger (default build).
// A second instance with CNT_W=4 shares the stimulus to exercise saturation.
module tb_march_fail_logger;
    import march_pkg::*;

    logic        clk = 1'b0;
    logic        reset, test_start, chk_valid, chk_fail, test_done, log_ready;
    logic [7:0]  chk_addr, chk_exp, chk_act;
    logic [2:0]  chk_step;
    logic [1:0]  chk_phase;

    logic        log_valid, ffv, overflow, done, pass, busy;
    logic [28:0] log_data;
    logic [15:0] fail_count, check_count;
    logic [7:0]  ffa;

    logic        lv4, ffv4, ov4, done4, pass4, busy4;
    logic [28:0] ld4;
    logic [3:0]  fc4, cc4;
    logic [7:0]  ffa4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    march_fail_logger u_dut (
        .clk(clk), .reset(reset), .test_start(test_start),
        .chk_valid(chk_valid), .chk_fail(chk_fail), .chk_addr(chk_addr),
        .chk_step(chk_step), .chk_phase(chk_phase), .chk_exp(chk_exp),
        .chk_act(chk_act), .test_done(test_done), .log_valid(log_valid),
        .log_ready(log_ready), .log_data(log_data), .fail_count(fail_count),
        .check_count(check_count), .first_fail_valid(ffv),
        .first_fail_addr(ffa), .overflow(overflow), .done(done),
        .pass(pass), .busy(busy)
    );

    march_fail_logger #(.CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .test_start(test_start),
        .chk_valid(chk_valid), .chk_fail(chk_fail), .chk_addr(chk_addr),
        .chk_step(chk_step), .chk_phase(chk_phase), .chk_exp(chk_exp),
        .chk_act(chk_act), .test_done(test_done), .log_valid(lv4),
        .log_ready(log_ready), .log_data(ld4), .fail_count(fc4),
        .check_count(cc4), .first_fail_valid(ffv4),
        .first_fail_addr(ffa4), .overflow(ov4), .done(done4),
        .pass(pass4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        test_start = 1'b1;
        tick();
        test_start = 1'b0;
    endtask

    // One compare cycle; the edge inside tick() samples it.
    task automatic compare(input logic fail, input logic [7:0] addr,
                           input logic [7:0] exp, input logic [7:0] act,
                           input logic [2:0] step, input logic [1:0] phase);
        chk_valid = 1'b1; chk_fail = fail; chk_addr = addr;
        chk_exp = exp; chk_act = act; chk_step = step; chk_phase = phase;
        tick();
        chk_valid = 1'b0; chk_fail = 1'b0;
    endtask

    task automatic test_reset();
        pulse_start();
        log_ready = 1'b0;
        for (int i = 0; i < 3; i++) compare(1'b1, 8'(i + 1), PAT0, 8'h00, 3'd2, 2'd0);
        n_cmp++; if (log_valid !== 1'b1 || fail_count !== 16'd3) begin n_bad++;
            $display("FAIL pre_reset_queue got lv=%b fc=%0d want lv=1 fc=3", log_valid, fail_count); end
        reset = 1'b0;
        tick();
        n_cmp++; if (log_valid !== 1'b0 || log_data !== 29'd0) begin n_bad++;
            $display("FAIL reset_log got lv=%b data=%h want lv=0 data=0", log_valid, log_data); end
        n_cmp++; if (fail_count !== 16'd0 || check_count !== 16'd0) begin n_bad++;
            $display("FAIL reset_counts got fc=%0d cc=%0d want 0 0", fail_count, check_count); end
        n_cmp++; if ({ffv, ffa, overflow, done, pass, busy} !== 13'd0) begin n_bad++;
            $display("FAIL reset_status got ffv=%b ffa=%h ov=%b done=%b pass=%b busy=%b want all 0",
                     ffv, ffa, overflow, done, pass, busy); end
        reset = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_bad++;
            $display("FAIL reset_idle got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_no_fail();
        logic lv_seen;
        lv_seen = 1'b0;
        pulse_start();
        n_cmp++; if (busy !== 1'b1) begin n_bad++;
            $display("FAIL start_busy got %b want 1", busy); end
        for (int i = 0; i < 512; i++) begin
            compare(1'b0, 8'(i), PAT1, PAT1, 3'(i % 7), 2'd0);
            if (log_valid) lv_seen = 1'b1;
        end
        test_done = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++;
            $display("FAIL nofail_drain got busy=%b done=%b want 1 0", busy, done); end
        tick();
        test_done = 1'b0;
        n_cmp++; if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin n_bad++;
            $display("FAIL nofail_verdict got done=%b pass=%b busy=%b want 1 1 0", done, pass, busy); end
        n_cmp++; if (check_count !== 16'd512 || fail_count !== 16'd0) begin n_bad++;
            $display("FAIL nofail_counts got cc=%0d fc=%0d want 512 0", check_count, fail_count); end
        n_cmp++; if (lv_seen !== 1'b0 || ffv !== 1'b0) begin n_bad++;
            $display("FAIL nofail_log got lv_seen=%b ffv=%b want 0 0", lv_seen, ffv); end
    endtask

    task automatic test_first_fail();
        pulse_start();
        log_ready = 1'b0;
        chk_valid = 1'b1; chk_fail = 1'b1; chk_addr = 8'h10;
        chk_exp = PAT0; chk_act = 8'h54; chk_step = 3'd1; chk_phase = 2'd0;
        #1;
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++;
            $display("FAIL no_bypass got lv=%b want 0", log_valid); end
        tick();
        chk_valid = 1'b0; chk_fail = 1'b0;
        n_cmp++; if (log_valid !== 1'b1 || log_data !== {3'd1, 2'd0, 8'h10, 8'h55, 8'h54}) begin n_bad++;
            $display("FAIL first_entry got lv=%b data=%h want lv=1 data=%h",
                     log_valid, log_data, {3'd1, 2'd0, 8'h10, 8'h55, 8'h54}); end
        compare(1'b0, 8'h18, PAT0, PAT0, 3'd1, 2'd1);
        compare(1'b1, 8'h20, PAT1, 8'hAB, 3'd2, 2'd1);
        n_cmp++; if (ffv !== 1'b1 || ffa !== 8'h10) begin n_bad++;
            $display("FAIL first_fail got ffv=%b ffa=%h want 1 10", ffv, ffa); end
        n_cmp++; if (fail_count !== 16'd2 || check_count !== 16'd3) begin n_bad++;
            $display("FAIL ff_counts got fc=%0d cc=%0d want 2 3", fail_count, check_count); end
        log_ready = 1'b1;
        tick();
        n_cmp++; if (log_valid !== 1'b1 || log_data !== {3'd2, 2'd1, 8'h20, 8'hAA, 8'hAB}) begin n_bad++;
            $display("FAIL second_entry got lv=%b data=%h want lv=1 data=%h",
                     log_valid, log_data, {3'd2, 2'd1, 8'h20, 8'hAA, 8'hAB}); end
        tick();
        log_ready = 1'b0;
        n_cmp++; if (log_valid !== 1'b0) begin n_bad++;
            $display("FAIL ff_emptied got lv=%b want 0", log_valid); end
    endtask

    task automatic test_overflow();
        int n;
        logic [7:0] addrs [$];
        pulse_start();
        log_ready = 1'b0;
        for (int i = 0; i < 16; i++) compare(1'b1, 8'(i), PAT0, 8'h00, 3'd3, 2'd0);
        n_cmp++; if (overflow !== 1'b0) begin n_bad++;
            $display("FAIL ov_at_full got %b want 0", overflow); end
        for (int i = 16; i < 20; i++) compare(1'b1, 8'(i), PAT0, 8'h00, 3'd3, 2'd0);
        n_cmp++; if (overflow !== 1'b1 || fail_count !== 16'd20) begin n_bad++;
            $display("FAIL ov_set got ov=%b fc=%0d want 1 20", overflow, fail_count); end
        log_ready = 1'b1;
        n = 0;
        while (log_valid && n < 40) begin addrs.push_back(log_data[23:16]); tick(); n++; end
        log_ready = 1'b0;
        n_cmp++; if (addrs.size() !== 16 || addrs[0] !== 8'd0 || addrs[15] !== 8'd15) begin n_bad++;
            $display("FAIL ov_kept got n=%0d first=%h last=%h want 16 00 0f",
                     addrs.size(), addrs[0], addrs[addrs.size()-1]); end
        // Full FIFO with a pop in the same cycle accepts the new entry.
        pulse_start();
        for (int i = 0; i < 16; i++) compare(1'b1, 8'(i), PAT0, 8'h00, 3'd3, 2'd0);
        log_ready = 1'b1;
        compare(1'b1, 8'hEE, PAT1, 8'h00, 3'd4, 2'd0);
        log_ready = 1'b0;
        n_cmp++; if (overflow !== 1'b0 || fail_count !== 16'd17) begin n_bad++;
            $display("FAIL full_pop_push got ov=%b fc=%0d want 0 17", overflow, fail_count); end
        addrs.delete();
        log_ready = 1'b1;
        n = 0;
        while (log_valid && n < 40) begin addrs.push_back(log_data[23:16]); tick(); n++; end
        log_ready = 1'b0;
        n_cmp++; if (addrs.size() !== 16 || addrs[0] !== 8'd1 || addrs[15] !== 8'hEE) begin n_bad++;
            $display("FAIL full_pop_order got n=%0d first=%h last=%h want 16 01 ee",
                     addrs.size(), addrs[0], addrs[addrs.size()-1]); end
    endtask

    task automatic test_drain();
        logic [28:0] head;
        pulse_start();
        log_ready = 1'b0;
        for (int i = 0; i < 4; i++) compare(1'b1, 8'(8'h31 + i), PAT1, 8'h2A, 3'd5, 2'd0);
        test_done = 1'b1;
        tick();
        head = {3'd5, 2'd0, 8'h31, 8'hAA, 8'h2A};
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++;
            $display("FAIL drain_state got busy=%b done=%b want 1 0", busy, done); end
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++; if (log_valid !== 1'b1 || log_data !== head) begin n_bad++;
                $display("FAIL backpressure_hold cyc%0d got lv=%b data=%h want lv=1 data=%h",
                         c, log_valid, log_data, head); end
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (log_data[23:16] !== 8'(8'h31 + k) || done !== 1'b0) begin n_bad++;
                $display("FAIL drain_pop%0d got addr=%h done=%b want %h 0",
                         k, log_data[23:16], done, 8'(8'h31 + k)); end
            log_ready = 1'b1;
            tick();
            log_ready = 1'b0;
        end
        n_cmp++; if (log_valid !== 1'b0 || done !== 1'b0) begin n_bad++;
            $display("FAIL drain_last got lv=%b done=%b want 0 0", log_valid, done); end
        tick();
        test_done = 1'b0;
        n_cmp++; if (done !== 1'b1 || pass !== 1'b0 || busy !== 1'b0) begin n_bad++;
            $display("FAIL drain_done got done=%b pass=%b busy=%b want 1 0 0", done, pass, busy); end
    endtask

    task automatic test_saturate_restart();
        int n;
        pulse_start();
        log_ready = 1'b0;
        for (int i = 0; i < 20; i++) compare(1'b1, 8'(i), PAT0, 8'hFF, 3'd6, 2'd0);
        n_cmp++; if (fc4 !== 4'd15 || cc4 !== 4'd15 || ov4 !== 1'b1) begin n_bad++;
            $display("FAIL sat4 got fc=%0d cc=%0d ov=%b want 15 15 1", fc4, cc4, ov4); end
        n_cmp++; if (fail_count !== 16'd20) begin n_bad++;
            $display("FAIL sat16 got fc=%0d want 20", fail_count); end
        test_done = 1'b1;
        log_ready = 1'b1;
        n = 0;
        while (!done4 && n < 40) begin tick(); n++; end
        test_done = 1'b0;
        log_ready = 1'b0;
        n_cmp++; if (done4 !== 1'b1 || pass4 !== 1'b0 || ov4 !== 1'b1) begin n_bad++;
            $display("FAIL sat_done got done=%b pass=%b ov=%b want 1 0 1", done4, pass4, ov4); end
        pulse_start();
        n_cmp++; if (fc4 !== 4'd0 || cc4 !== 4'd0 || ov4 !== 1'b0 || ffv4 !== 1'b0) begin n_bad++;
            $display("FAIL restart_clear got fc=%0d cc=%0d ov=%b ffv=%b want 0 0 0 0", fc4, cc4, ov4, ffv4); end
        n_cmp++; if (busy4 !== 1'b1 || done4 !== 1'b0 || pass4 !== 1'b0 || lv4 !== 1'b0) begin n_bad++;
            $display("FAIL restart_state got busy=%b done=%b pass=%b lv=%b want 1 0 0 0", busy4, done4, pass4, lv4); end
        // test_start beats a simultaneous test_done: state stays RUN.
        test_start = 1'b1; test_done = 1'b1;
        tick();
        test_start = 1'b0; test_done = 1'b0;
        tick();
        n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin n_bad++;
            $display("FAIL start_prio got busy=%b done=%b want 1 0", busy, done); end
    endtask

    initial begin
        reset = 1'b0; test_start = 1'b0; chk_valid = 1'b0; chk_fail = 1'b0;
        chk_addr = '0; chk_exp = '0; chk_act = '0; chk_step = '0; chk_phase = '0;
        test_done = 1'b0; log_ready = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        test_reset();
        test_no_fail();
        test_first_fail();
        test_overflow();
        test_drain();
        test_saturate_restart();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "timeout");
    end

endmodule
